// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NUM_REQ requesters with start/done timeouts
// Define UART_ARB_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 20832,
  parameter int DONE_TIMEOUT  = 125000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CW   = IDW + 1;
  localparam int TMAX = (START_TIMEOUT > DONE_TIMEOUT) ? START_TIMEOUT : DONE_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               arb_busy_q, arb_busy_d;
  logic               timeout_err_q, timeout_err_d;

  logic               sel_valid;
  logic [IDW-1:0]     sel_idx;
  logic [DATA_W-1:0]  sel_byte;
  logic [IDW-1:0]     next_rr;
  logic               start_to, done_to;

  assign start_to = (timer_q == START_LAST);
  assign done_to  = (timer_q == DONE_LAST);

`ifdef UART_ARB_PRIO_EN
  assign next_rr = '0;
`else
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  assign next_rr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
`endif

  // First set request bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [CW-1:0] cand;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!sel_valid && req[cand[IDW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDW'(i)) sel_byte = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      rr_ptr_q      <= '0;
      ack_q         <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      grant_id_q    <= '0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rr_ptr_q      <= rr_ptr_d;
      ack_q         <= ack_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      grant_id_q    <= grant_id_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (sel_valid) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)       state_d = WAIT_DONE;
        else if (start_to) state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy || done_to) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d         = '0;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    timer_d       = timer_q + TW'(1);
    rr_ptr_d      = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (sel_valid) begin
          ack_d      = NUM_REQ'(1) << sel_idx;
          tx_data_d  = sel_byte;
          grant_id_d = sel_idx;
          tx_start_d = 1'b1;
        end
      end
      // tx_start stays up until busy is seen: the transmitter samples it only on its baud tick.
      WAIT_BUSY: begin
        if (tx_busy) begin
          timer_d = '0;
        end else if (start_to) begin
          timer_d       = '0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_rr;
        end else begin
          tx_start_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          timer_d  = '0;
          rr_ptr_d = next_rr;
        end else if (done_to) begin
          timer_d       = '0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_rr;
        end
      end
      default: timer_d = '0;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int N      = 4;
  localparam int M_NORM = 0;
  localparam int M_STO  = 1;
  localparam int M_DTO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int          n_chk = 0;
  int          n_bad = 0;
  int          m_rr;
  logic [7:0]  bytes[N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .START_TIMEOUT(16), .DONE_TIMEOUT(32)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_advance(input int g);
`ifdef UART_ARB_PRIO_EN
    m_rr = 0;
`else
    m_rr = (g + 1) % N;
`endif
  endfunction

  // One full arbitration: grant, transmitter handshake, completion or timeout.
  task automatic do_frame(input logic [3:0] r, input logic [3:0] r_after, input int delay,
                          input int hold, input int mode, input bit scr,
                          output int got_g, output int got_d);
    int         g;
    int         cnt;
    logic [7:0] exp_byte;
    g = model_pick(r);
    exp_byte = bytes[g];
    req = r;
    tick();
    chk("ack", 32'(ack), 32'(1) << g);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("tx_data", 32'(tx_data), 32'(exp_byte));
    chk("tx_start_rise", 32'(tx_start), 32'd1);
    chk("arb_busy_rise", 32'(arb_busy), 32'd1);
    chk("no_err_at_grant", 32'(timeout_err), 32'd0);
    got_g = int'(grant_id);
    got_d = int'(tx_data);
    req = r_after;
    if (scr) begin
      bytes[g] = 8'($urandom);
      drive_data();
    end
    cnt = 1;
    if (mode == M_STO) begin
      for (int i = 0; i < 40 && tx_start; i++) begin
        tick();
        if (tx_start) cnt++;
      end
      chk("start_to_len", 32'(cnt), 32'd16);
      chk("start_to_err", 32'(timeout_err), 32'd1);
      chk("start_to_idle", 32'(arb_busy), 32'd0);
    end else begin
      repeat (delay) begin
        tick();
        if (tx_start) cnt++;
      end
      tx_busy = 1'b1;
      tick();
      chk("start_len", 32'(cnt), 32'(delay + 1));
      chk("start_drop", 32'(tx_start), 32'd0);
      chk("ack_single", 32'(ack), 32'd0);
      chk("busy_in_frame", 32'(arb_busy), 32'd1);
      if (mode == M_DTO) begin
        cnt = 0;
        for (int i = 0; i < 60 && !timeout_err; i++) begin
          tick();
          cnt++;
        end
        chk("done_to_len", 32'(cnt), 32'd32);
        chk("done_to_err", 32'(timeout_err), 32'd1);
        chk("done_to_idle", 32'(arb_busy), 32'd0);
        tx_busy = 1'b0;
      end else begin
        repeat (hold - 1) tick();
        chk("busy_hold", 32'(arb_busy), 32'd1);
        chk("tx_data_stable", 32'(tx_data), 32'(exp_byte));
        tx_busy = 1'b0;
        tick();
        chk("arb_busy_fall", 32'(arb_busy), 32'd0);
        chk("no_err_done", 32'(timeout_err), 32'd0);
      end
    end
    model_advance(g);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int d;
    int exp_c[5];
    reset   = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    for (int i = 0; i < N; i++) bytes[i] = 8'h00;
    drive_data();
    m_rr = 0;
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_no_req", 32'(arb_busy), 32'd0);

    // Contention with all four requesting and holding their levels.
`ifdef UART_ARB_PRIO_EN
    exp_c = '{0, 0, 0, 0, 0};
`else
    exp_c = '{0, 1, 2, 3, 0};
`endif
    bytes[0] = 8'h10; bytes[1] = 8'h11; bytes[2] = 8'h12; bytes[3] = 8'h13;
    drive_data();
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, 4'b1111, 3, 6, M_NORM, 1'b0, g, d);
      chk("cont_gid", 32'(g), 32'(exp_c[i]));
      chk("cont_data", 32'(d), 32'(8'h10 + exp_c[i]));
    end

    bytes[1] = 8'hA5;
    drive_data();
    do_frame(4'b0010, 4'b0000, 5, 20, M_NORM, 1'b0, g, d);
    chk("single_gid", 32'(g), 32'd1);
    chk("single_data", 32'(d), 32'hA5);

    do_frame(4'b1000, 4'b0000, 2, 4, M_NORM, 1'b0, g, d);
    chk("wrap_gid3", 32'(g), 32'd3);
    do_frame(4'b1001, 4'b1001, 2, 4, M_NORM, 1'b0, g, d);
    chk("wrap_gid0", 32'(g), 32'd0);
    do_frame(4'b1001, 4'b0000, 2, 4, M_NORM, 1'b0, g, d);
`ifdef UART_ARB_PRIO_EN
    chk("wrap_fair", 32'(g), 32'd0);
`else
    chk("wrap_fair", 32'(g), 32'd3);
`endif

    do_frame(4'b0100, 4'b0000, 0, 0, M_STO, 1'b0, g, d);
    chk("sto_gid", 32'(g), 32'd2);
    do_frame(4'b1101, 4'b0000, 1, 3, M_NORM, 1'b0, g, d);
`ifdef UART_ARB_PRIO_EN
    chk("after_sto_gid", 32'(g), 32'd0);
`else
    chk("after_sto_gid", 32'(g), 32'd3);
`endif

    do_frame(4'b0010, 4'b0000, 4, 0, M_DTO, 1'b0, g, d);
    chk("dto_gid", 32'(g), 32'd1);
    tick();
    chk("dto_err_pulse", 32'(timeout_err), 32'd0);

    // Reset three cycles into WAIT_BUSY.
    g = model_pick(4'b0100);
    req = 4'b0100;
    tick();
    chk("rstmid_grant", 32'(grant_id), 32'(g));
    req = 4'b0000;
    repeat (3) tick();
    chk("rstmid_pre", 32'(tx_start), 32'd1);
    reset = 1'b1;
    tick();
    chk("rstmid_tx_start", 32'(tx_start), 32'd0);
    chk("rstmid_arb_busy", 32'(arb_busy), 32'd0);
    chk("rstmid_grant_id", 32'(grant_id), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    m_rr = 0;
    do_frame(4'b1010, 4'b0000, 2, 3, M_NORM, 1'b0, g, d);
    chk("rstmid_regrant", 32'(g), 32'd1);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] r;
      int         mode;
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
      drive_data();
      if (r == 4'b0) begin
        req = r;
        tick();
        chk("rnd_idle_busy", 32'(arb_busy), 32'd0);
        chk("rnd_idle_ack", 32'(ack), 32'd0);
        continue;
      end
      mode = $urandom_range(0, 9);
      mode = (mode == 0) ? M_STO : (mode == 1) ? M_DTO : M_NORM;
      do_frame(r, ($urandom_range(0, 1) != 0) ? r : 4'b0000, $urandom_range(0, 10),
               $urandom_range(1, 20), mode, 1'b1, g, d);
    end

    req = '0;
    tick();
    tick();
    chk("final_idle", 32'(arb_busy), 32'd0);
    chk("final_err", 32'(timeout_err), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
